// File: rtl/calc_arbiter.sv
// Round-robin arbiter that shares one Small_Calculator between NREQ requesters.
// Optional macro CALC_ARB_TIMEOUT_EN aborts an operation after TIMEOUT WAIT cycles.
module calc_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     Req,
    input  logic [2*NREQ-1:0]   Op,
    input  logic [3*NREQ-1:0]   In1,
    input  logic [3*NREQ-1:0]   In2,
    output logic [NREQ-1:0]     Ack,
    output logic [2:0]          Result,
    output logic                Err,
    output logic                Busy,
    output logic [1:0]          Gnt_Id,
    output logic                Calc_Go,
    output logic [1:0]          Calc_Op,
    output logic [2:0]          Calc_In1,
    output logic [2:0]          Calc_In2,
    input  logic                Calc_Done,
    input  logic [2:0]          Calc_Out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q;
    logic [1:0]  ptr_next;
    logic        win_found;
    logic [1:0]  win_id;
    logic        grant, finish, abort;
    logic        timeout_hit;
    logic        err_q;
    logic [3:0]  req_ext;
    logic [7:0]  op_ext;
    logic [11:0] in1_ext, in2_ext;
    logic [3:0]  in_base;
    logic [NREQ-1:0] ack_set;

    // Requester buses widened to four slots so selection works for any NREQ
    assign req_ext = 4'(Req);
    assign op_ext  = 8'(Op);
    assign in1_ext = 12'(In1);
    assign in2_ext = 12'(In2);
    assign in_base = 4'(win_id) * 4'd3;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = 2'd0;
        idx       = 0;
        // Walk from the farthest slot back so the slot nearest Ptr wins
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (req_ext[2'(idx)]) begin
                win_found = 1'b1;
                win_id    = 2'(idx);
            end
        end
    end

    assign ptr_next = (win_id == 2'(NREQ - 1)) ? 2'd0 : win_id + 2'd1;
    assign ack_set  = {{(NREQ-1){1'b0}}, 1'b1} << Gnt_Id;

`ifdef CALC_ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LIM = 4'(TIMEOUT - 1);
    logic [3:0] to_cnt_q;

    // Counter value k-1 at the k-th WAIT edge, so the limit fires at edge TIMEOUT
    always_ff @(posedge CLK) begin
        if (RST)
            to_cnt_q <= 4'd0;
        else if (grant)
            to_cnt_q <= 4'd0;
        else if (state_q == S_WAIT)
            to_cnt_q <= to_cnt_q + 4'd1;
    end

    assign timeout_hit = (to_cnt_q == TO_LIM);
    assign Err         = err_q;
`else
    assign timeout_hit = 1'b0;
    assign Err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Calc_Done) begin
                    finish  = 1'b1;
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= 2'd0;
            Gnt_Id   <= 2'd0;
            Calc_Go  <= 1'b0;
            Calc_Op  <= 2'd0;
            Calc_In1 <= 3'd0;
            Calc_In2 <= 3'd0;
            Ack      <= '0;
            Result   <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                Calc_Op  <= op_ext[{win_id, 1'b0} +: 2];
                Calc_In1 <= in1_ext[in_base +: 3];
                Calc_In2 <= in2_ext[in_base +: 3];
                Gnt_Id   <= win_id;
                ptr_q    <= ptr_next;
                Calc_Go  <= 1'b1;
            end
            // Ack and Err are single-cycle pulses; they clear on every other edge
            if (finish || abort) begin
                Result  <= finish ? Calc_Out : 3'd0;
                Ack     <= ack_set;
                err_q   <= abort;
                Calc_Go <= 1'b0;
            end else begin
                Ack   <= '0;
                err_q <= 1'b0;
            end
        end
    end

    assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: environment calculator, timing-level reference model,
// directed scenarios followed by randomized traffic.
module tb_calc_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;
`ifdef CALC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   Req = '0;
    logic [2*N-1:0] Op  = '0;
    logic [3*N-1:0] In1 = '0;
    logic [3*N-1:0] In2 = '0;
    logic [N-1:0]   Ack;
    logic [2:0]     Result;
    logic           Err;
    logic           Busy;
    logic [1:0]     Gnt_Id;
    logic           Calc_Go;
    logic [1:0]     Calc_Op;
    logic [2:0]     Calc_In1;
    logic [2:0]     Calc_In2;
    logic           calc_done = 1'b0;
    logic [2:0]     calc_out  = 3'd0;
    logic [2:0]     calc_cnt  = 3'd0;
    bit             calc_dead = 1'b0;

    calc_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .Req(Req), .Op(Op), .In1(In1), .In2(In2),
        .Ack(Ack), .Result(Result), .Err(Err), .Busy(Busy), .Gnt_Id(Gnt_Id),
        .Calc_Go(Calc_Go), .Calc_Op(Calc_Op), .Calc_In1(Calc_In1),
        .Calc_In2(Calc_In2), .Calc_Done(calc_done), .Calc_Out(calc_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] alu(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        case (op)
            2'b11:   return a + b;
            2'b10:   return a - b;
            2'b01:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Calculator stand-in: Done rises four edges after Go is first seen
    always @(posedge CLK) begin
        if (!Calc_Go || calc_dead) begin
            calc_cnt  <= 3'd0;
            calc_done <= 1'b0;
        end else if (calc_cnt < 3'd3) begin
            calc_cnt <= calc_cnt + 3'd1;
        end else begin
            calc_done <= 1'b1;
            calc_out  <= alu(Calc_Op, Calc_In1, Calc_In2);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_result(input int op, input int a, input int b);
        case (op)
            3:       return (a + b) % 8;
            2:       return (a - b + 8) % 8;
            1:       return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Reference model: an operation granted at edge g completes at edge d
    int e = 0;
    bit in_op = 0;
    bit m_dead = 0;
    int g_e = 0, d_e = 0;
    int m_ptr = 0, m_gnt = 0, m_res = 0, m_op = 0, m_a = 0, m_b = 0;
    int obs_id[$];
    int obs_edge[$];

    task automatic model_edge();
        int w;
        e++;
        if (RST) begin
            in_op = 0; m_ptr = 0; m_gnt = 0; m_res = 0;
            m_op = 0; m_a = 0; m_b = 0;
        end else begin
            if (in_op && e == d_e)
                m_res = m_dead ? 0 : ref_result(m_op, m_a, m_b);
            if ((!in_op || e >= d_e + 2) && Req != 0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && Req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                in_op  = 1;
                g_e    = e;
                m_dead = calc_dead;
                d_e    = e + (calc_dead ? (TO_EN ? TO : 1000000) : 5);
                m_op   = int'(Op[2*w +: 2]);
                m_a    = int'(In1[3*w +: 3]);
                m_b    = int'(In2[3*w +: 3]);
                m_gnt  = w;
                m_ptr  = (w + 1) % N;
            end
        end
    endtask

    task automatic compare_all();
        int exp_ack;
        exp_ack = (in_op && e == d_e) ? (1 << m_gnt) : 0;
        check_eq("busy",   int'(Busy),    int'(in_op && e >= g_e && e <= d_e));
        check_eq("go",     int'(Calc_Go), int'(in_op && e < d_e));
        check_eq("ack",    int'(Ack),     exp_ack);
        check_eq("err",    int'(Err),     int'(exp_ack != 0 && m_dead && TO_EN));
        check_eq("result", int'(Result),  m_res);
        check_eq("gnt_id", int'(Gnt_Id),  m_gnt);
        check_eq("op",     int'(Calc_Op), m_op);
        check_eq("in1",    int'(Calc_In1), m_a);
        check_eq("in2",    int'(Calc_In2), m_b);
        for (int k = 0; k < N; k++)
            if (Ack[k]) begin
                obs_id.push_back(k);
                obs_edge.push_back(e);
            end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int i, input int op, input int a, input int b);
        Op[2*i +: 2]  = 2'(op);
        In1[3*i +: 3] = 3'(a);
        In2[3*i +: 3] = 3'(b);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        Req = '0;
        ticks(2);
        RST = 1'b0;
    endtask

    initial begin
        int e0;
        int base;
        // Reset and idle
        ticks(2);
        RST = 1'b0;
        ticks(5);

        // Single add with wrap: 3 + 6 -> 1
        set_req(0, 3, 3, 6);
        obs_id.delete(); obs_edge.delete();
        e0 = e;
        Req = 4'b0001;
        tick();
        Req = 4'b0000;
        ticks(8);
        check_eq("t1_ack_count", obs_id.size(), 1);
        if (obs_id.size() == 1) begin
            check_eq("t1_ack_id",   obs_id[0], 0);
            check_eq("t1_ack_edge", obs_edge[0] - e0, 6);
        end
        check_eq("t1_result", int'(Result), 1);

        // All four requesting: rotation order and 7-cycle spacing
        do_reset();
        set_req(0, 3, 1, 2);
        set_req(1, 1, 6, 3);
        set_req(2, 2, 2, 5);
        set_req(3, 0, 5, 3);
        obs_id.delete(); obs_edge.delete();
        Req = 4'b1111;
        ticks(35);
        Req = 4'b0000;
        ticks(8);
        check_eq("t2_ack_count", obs_id.size(), 5);
        for (int k = 0; k < 5 && k < obs_id.size(); k++) begin
            check_eq("t2_order", obs_id[k], k % 4);
            if (k > 0) check_eq("t2_spacing", obs_edge[k] - obs_edge[k-1], 7);
        end

        // Operands change after grant; requester 1 drops Req mid-WAIT
        do_reset();
        set_req(1, 3, 2, 3);
        obs_id.delete(); obs_edge.delete();
        Req = 4'b0010;
        tick();
        set_req(1, 3, 7, 3);
        ticks(2);
        Req = 4'b0000;
        ticks(6);
        check_eq("t3_ack_count", obs_id.size(), 1);
        if (obs_id.size() == 1) check_eq("t3_ack_id", obs_id[0], 1);
        check_eq("t3_result", int'(Result), 5);

        // Reset three edges into WAIT drops the operation
        do_reset();
        set_req(0, 2, 6, 1);
        obs_id.delete(); obs_edge.delete();
        Req = 4'b0001;
        ticks(3);
        RST = 1'b1;
        tick();
        check_eq("t4_go_after_rst",   int'(Calc_Go), 0);
        check_eq("t4_busy_after_rst", int'(Busy), 0);
        RST = 1'b0;
        tick();
        Req = 4'b0000;
        ticks(8);
        check_eq("t4_ack_count", obs_id.size(), 1);
        check_eq("t4_result", int'(Result), 5);

        // Calculator never answers
        do_reset();
        calc_dead = 1'b1;
        set_req(2, 3, 4, 4);
        obs_id.delete(); obs_edge.delete();
        e0 = e;
        Req = 4'b0100;
        tick();
        Req = 4'b0000;
        if (TO_EN) begin
            ticks(20);
            check_eq("t5_ack_count", obs_id.size(), 1);
            if (obs_id.size() == 1) check_eq("t5_ack_edge", obs_edge[0] - e0, TO + 1);
        end else begin
            ticks(100);
            check_eq("t5_busy_held", int'(Busy), 1);
            check_eq("t5_ack_count", obs_id.size(), 0);
        end
        do_reset();
        calc_dead = 1'b0;

        // Randomized traffic
        base = n_fail;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) Req = 4'($urandom);
            Op  = 8'($urandom);
            In1 = 12'($urandom);
            In2 = 12'($urandom);
            tick();
        end
        Req = '0;
        ticks(10);
        check_eq("rand_phase_clean", n_fail - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Round-robin arbiter and sequencer that shares one Small_Calculator datapath between up to four requesters. Each requester presents an opcode and two 3-bit operands under a level request. The arbiter grants one requester at a time, latches its operands, drives the calculator's Go/Op/In1/In2, waits for Done, and returns the 3-bit result with a one-cycle Ack. It sits between client logic and the calculator and is the only driver of the calculator's inputs.

## Interface
- NREQ, 4: number of requesters, 2..4.
- TIMEOUT, 15: WAIT-cycle limit before abort; used only with CALC_ARB_TIMEOUT_EN, 1..15.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- Req  in  NREQ  per-requester level request.
- Op  in  2*NREQ  opcode of requester i at [2i+1:2i]: 11 add, 10 sub, 01 and, 00 xor.
- In1, In2  in  3*NREQ  operands of requester i at [3i+2:3i].
- Ack  out  NREQ  one-cycle completion pulse to the granted requester.
- Result  out  3  result, valid while Ack is non-zero; holds until next completion.
- Err  out  1  pulses with Ack on a timeout abort; constant 0 without the macro.
- Busy  out  1  high in any state other than IDLE.
- Gnt_Id  out  2  index of current or last granted requester.
- Calc_Go  out  1  Go to calculator.
- Calc_Op  out  2, Calc_In1 / Calc_In2  out  3  latched operands to calculator.
- Calc_Done  in  1, Calc_Out  in  3  from calculator.

## Operation
- FSM: IDLE, WAIT, RELEASE.
- IDLE: if any Req bit is set, pick winner by round-robin starting at pointer Ptr. At that edge:
  - latch winner's Op/In1/In2 into Calc_Op/Calc_In1/Calc_In2;
  - Gnt_Id <= winner; Ptr <= winner+1 (mod NREQ); Calc_Go <= 1; go to WAIT.
- WAIT: Calc_Go held 1 and operands held stable. When Calc_Done=1 is sampled:
  - Result <= Calc_Out; Ack[Gnt_Id] <= 1; Calc_Go <= 0; go to RELEASE.
- RELEASE: Ack high for this cycle only and Calc_Go low. Next edge: Ack <= 0, go to IDLE.
- Calc_Go is low for at least 2 cycles (RELEASE plus IDLE) between operations, which returns the calculator to S0.
- Operands are sampled only at the grant edge. Later changes on the winner's inputs are ignored.
- Requester drops Req in the cycle after Ack, or it is re-arbitrated. Round-robin places it last.
- Req dropped after grant: the operation still completes and Ack still pulses.
- Calc_Done sampled outside WAIT: ignored.
- Result is produced by the calculator (3-bit wrap). The arbiter does no arithmetic.
- Reset at any point: state IDLE, Ptr=0, Gnt_Id=0, Calc_Go=0, Calc_Op/In1/In2=0, Ack=0, Result=0, Err=0, Busy=0. Any in-flight operation is dropped with no Ack. The calculator returns to S0 on its own because Go is low.

## Timing
- Grant edge at cycle t (IDLE, Req seen). Calc_Go=1 from t+1. The calculator raises Done 4 cycles after first seeing Go=1, so Calc_Done is sampled at t+5.
- Ack and Result visible at t+6, Busy low at t+7.
- Back-to-back requests: next grant edge at t+7, so throughput is 1 operation per 7 cycles.
- Busy = (state != IDLE), registered through the state.

## Configuration
- CALC_ARB_TIMEOUT_EN defined:
  - A 4-bit counter clears at the grant edge and increments each WAIT cycle.
  - If it reaches TIMEOUT with Calc_Done=0: Result <= 0, Ack[Gnt_Id] <= 1, Err <= 1, Calc_Go <= 0, go to RELEASE. Err clears with Ack.
  - If Calc_Done=1 in the same cycle the counter reaches TIMEOUT, Done wins and Err=0.
- Not defined: no counter. WAIT lasts until Calc_Done, and Err is tied 0.

## Test plan
- Reset then idle 5 cycles: all outputs 0, Calc_Go=0, Busy=0.
- Req=0001, Op0=11, In1=3, In2=6, with Small_Calculator attached: grant at t, Ack=0001 at t+6, Result=1 (wrap), Err=0.
- Req=1111 held, operands distinct per requester: Ack order 0,1,2,3,0, grants 7 cycles apart; each Result matches its opcode (e.g. requester 2 sub 2-5 -> 5).
- Winner changes In1 after grant; requester 1 drops Req during WAIT: Results use the grant-time operands, and requester 1 still receives Ack.
- RST asserted at t+3 mid-WAIT: next cycle Calc_Go=0, Busy=0, no Ack; a new Req after reset completes normally.
- With CALC_ARB_TIMEOUT_EN, TIMEOUT=15, Calc_Done tied 0: Ack and Err pulse 16 cycles after the grant edge with Result=0; without the macro, Busy stays 1 for 100 cycles.
